// File: rtl/answer_judge.sv
// Answer-checking unit: latches the expected factor pair, judges submissions order-independently,
// tracks wrong answers per question. Define ANSWER_JUDGE_TIMEOUT_EN to compile in the answer timer.
module answer_judge #(
  parameter int TIME_LIMIT = 500_000_000,
  parameter int W          = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                QUE,
  input  logic signed [W-1:0] EXP_P,
  input  logic signed [W-1:0] EXP_Q,
  input  logic signed [W-1:0] ANS_A,
  input  logic signed [W-1:0] ANS_B,
  input  logic                SUBMIT,
  output logic [1:0]          JUDG,
  output logic                OK,
  output logic [1:0]          WRONG,
  output logic                BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_RESULT} state_t;

  localparam logic [1:0] J_NONE    = 2'b00;
  localparam logic [1:0] J_CORRECT = 2'b01;
  localparam logic [1:0] J_WRONG   = 2'b10;
  localparam logic [1:0] J_TIMEOUT = 2'b11;

  if (TIME_LIMIT < 2) begin : g_bad_time_limit
    $error("answer_judge: TIME_LIMIT must be at least 2");
  end

  state_t              state_q, state_d;
  logic signed [W-1:0] fac_p_q, fac_p_d, fac_q_q, fac_q_d;
  logic signed [W-1:0] ans_a_q, ans_a_d, ans_b_q, ans_b_d;
  logic [1:0]          judg_q, judg_d;
  logic [1:0]          wrong_q, wrong_d;
  logic                ok_q, ok_d;
  logic                busy_q, busy_d;
  logic                expired;
  logic                match;

`ifdef ANSWER_JUDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIME_LIMIT);

  logic [TW-1:0] timer_q, timer_d;

  assign expired = (timer_q == '0);

  // Timer parks at zero so an expiry during CHECK is still seen on the return to WAIT.
  always_comb begin
    timer_d = timer_q;
    if (state_q == S_IDLE && QUE) begin
      timer_d = TW'(TIME_LIMIT - 1);
    end else if ((state_q == S_WAIT || state_q == S_CHECK) && !expired) begin
      timer_d = timer_q - TW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign expired = 1'b0;
`endif

  assign match = ((ans_a_q == fac_p_q) && (ans_b_q == fac_q_q)) ||
                 ((ans_a_q == fac_q_q) && (ans_b_q == fac_p_q));

  // NOTE: every next-state variable gets its default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    fac_p_d = fac_p_q;
    fac_q_d = fac_q_q;
    ans_a_d = ans_a_q;
    ans_b_d = ans_b_q;
    judg_d  = J_NONE;
    ok_d    = ok_q;
    wrong_d = wrong_q;
    unique case (state_q)
      S_IDLE: begin
        if (QUE) begin
          fac_p_d = EXP_P;
          fac_q_d = EXP_Q;
          ok_d    = 1'b0;
          wrong_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (SUBMIT) begin
          ans_a_d = ANS_A;
          ans_b_d = ANS_B;
          state_d = S_CHECK;
        end else if (expired) begin
          judg_d  = J_TIMEOUT;
          state_d = S_RESULT;
        end
      end
      S_CHECK: begin
        judg_d  = match ? J_CORRECT : J_WRONG;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        // judg_q holds the code decided on entry, so it doubles as the result register.
        unique case (judg_q)
          J_CORRECT: begin
            ok_d    = 1'b1;
            state_d = S_IDLE;
          end
          J_WRONG: begin
            if (wrong_q != 2'b11) wrong_d = wrong_q + 2'b01;
            state_d = S_WAIT;
          end
          default: state_d = S_IDLE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      fac_p_q <= '0;
      fac_q_q <= '0;
      ans_a_q <= '0;
      ans_b_q <= '0;
      judg_q  <= J_NONE;
      ok_q    <= 1'b0;
      wrong_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fac_p_q <= fac_p_d;
      fac_q_q <= fac_q_d;
      ans_a_q <= ans_a_d;
      ans_b_q <= ans_b_d;
      judg_q  <= judg_d;
      ok_q    <= ok_d;
      wrong_q <= wrong_d;
      busy_q  <= busy_d;
    end
  end

  assign JUDG  = judg_q;
  assign OK    = ok_q;
  assign WRONG = wrong_q;
  assign BUSY  = busy_q;

endmodule
